flash_sd_spi_ctrl: RTL and testbench

- Z80-bus peripheral providing one shared SPI master engine for the boot SPI flash and the SD card.
- Flash is reached through ZX-Uno register-file data accesses: `addr`/`ior`/`iow`, decoded upstream by the ZX-Uno register block.
- SD is reached through ZXMMC-style I/O ports decoded directly from `a`/`iorq_n`/`rd_n`/`wr_n`.
- Sits between the CPU data bus mux and the flash/SD pins. It can stall the CPU through `wait_n`, which drives the CPU clock enable.

---
 rtl/flash_sd_spi_ctrl_pkg.sv | 29 ++
 rtl/flash_sd_spi_ctrl_if.sv | 26 ++
 rtl/flash_sd_spi_ctrl_spi_shifter.sv | 84 ++++++++
 rtl/flash_sd_spi_ctrl.sv | 104 ++++++++++
 tb/tb_flash_sd_spi_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_sd_spi_ctrl_pkg.sv
// Shared constants and types for the flash/SD SPI peripheral.
// Holds the register/port numbers, the SPI bit timing, the shifter states and the access-decode vector.
package flash_sd_pkg;

    localparam logic [7:0] FLASHSPI_ADDR = 8'h02;
    localparam logic [7:0] FLASHCS_ADDR  = 8'h03;
    localparam logic [7:0] SDCS_PORT     = 8'hE7;
    localparam logic [7:0] SDDATA_PORT   = 8'hEB;

    localparam int unsigned SPI_BIT_PERIOD  = 2;
    localparam int unsigned SPI_XFER_CYCLES = 8 * SPI_BIT_PERIOD;

    typedef enum logic {
        SH_IDLE,
        SH_XFER
    } sh_state_t;

    // One bit per decoded access term; rising edges are taken on the whole vector.
    typedef struct packed {
        logic fw;   // flash data write
        logic fr;   // flash data read
        logic fcw;  // flash chip-select write
        logic fcr;  // flash chip-select read
        logic sw;   // SD data write
        logic sr;   // SD data read
        logic scw;  // SD chip-select write
    } acc_t;

endpackage

// File: rtl/flash_sd_spi_ctrl_if.sv
// CPU-side bus of the flash/SD SPI peripheral: Z80 strobes, ZX-Uno register access and read-back.
interface flash_sd_spi_ctrl_if;

    logic [15:0] a;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  addr;
    logic        ior;
    logic        iow;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe;
    logic        wait_n;

    modport master (
        output a, iorq_n, rd_n, wr_n, addr, ior, iow, din,
        input  dout, oe, wait_n
    );

    modport slave (
        input  a, iorq_n, rd_n, wr_n, addr, ior, iow, din,
        output dout, oe, wait_n
    );

endinterface

// File: rtl/flash_sd_spi_ctrl_spi_shifter.sv
// 8-bit SPI mode-0 shift engine, MSB first, two clk cycles per bit.
// done/rx_byte are valid in the last cycle so the caller can capture the byte as sclk returns low.
module spi_shifter
    import flash_sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte
);

    localparam logic [3:0] XFER_LAST = 4'(SPI_XFER_CYCLES - 1);

    sh_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sreg_q, sreg_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SH_IDLE;
            cnt_q   <= '0;
            sreg_q  <= '1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        done    = 1'b0;
        case (state_q)
            SH_IDLE: begin
                if (start) begin
                    state_d = SH_XFER;
                    cnt_d   = '0;
                    sreg_d  = tx_byte;
                    sclk_d  = 1'b0;
                    mosi_d  = tx_byte[7];
                end
            end
            SH_XFER: begin
                cnt_d = cnt_q + 4'd1;
                if (!cnt_q[0]) begin
                    sclk_d = 1'b1;
                end else begin
                    // End of the high phase: MISO is sampled and the next bit goes out.
                    sclk_d = 1'b0;
                    sreg_d = {sreg_q[6:0], miso};
                    mosi_d = sreg_q[6];
                    if (cnt_q == XFER_LAST) begin
                        done    = 1'b1;
                        state_d = SH_IDLE;
                        mosi_d  = 1'b1;
                    end
                end
            end
            default: state_d = SH_IDLE;
        endcase
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign busy    = (state_q == SH_XFER);
    assign rx_byte = {sreg_q[6:0], miso};

endmodule

// File: rtl/flash_sd_spi_ctrl.sv
// Shared SPI master for the boot flash (ZX-Uno registers) and the SD card (ZXMMC ports).
// Build option SPI_WAIT_EN: hold wait_n low for the duration of each transfer.
module flash_sd_spi_ctrl
    import flash_sd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    flash_sd_spi_ctrl_if.slave bus,
    input  logic               in_boot_mode,
    output logic               flash_cs_n,
    output logic               flash_clk,
    output logic               flash_di,
    input  logic               flash_do,
    input  logic               disable_spisd,
    output logic               sd_cs_n,
    output logic               sd_clk,
    output logic               sd_mosi,
    input  logic               sd_miso
);

    acc_t       cur, prev, rise;
    logic       io_wr, io_rd;
    logic       start_req, start_flash, start_wr;
    logic       tgt_sd;
    logic [7:0] rx_buf, dout_q, tx_byte, rx_byte;
    logic       sclk, mosi, busy, done, miso;

    assign io_wr = !bus.iorq_n && !bus.wr_n && !disable_spisd;
    assign io_rd = !bus.iorq_n && !bus.rd_n && !disable_spisd;

    always_comb begin
        cur     = '0;
        cur.fw  = in_boot_mode && bus.iow && (bus.addr == FLASHSPI_ADDR);
        cur.fr  = in_boot_mode && bus.ior && (bus.addr == FLASHSPI_ADDR);
        cur.fcw = in_boot_mode && bus.iow && (bus.addr == FLASHCS_ADDR);
        cur.fcr = in_boot_mode && bus.ior && (bus.addr == FLASHCS_ADDR);
        cur.sw  = io_wr && (bus.a[7:0] == SDDATA_PORT);
        cur.sr  = io_rd && (bus.a[7:0] == SDDATA_PORT);
        cur.scw = io_wr && (bus.a[7:0] == SDCS_PORT);
    end

    assign rise        = acc_t'(cur & ~prev);
    assign start_flash = rise.fw || rise.fr;
    assign start_wr    = rise.fw || rise.sw;
    assign start_req   = start_flash || rise.sw || rise.sr;
    assign tx_byte     = start_wr ? bus.din : 8'hFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            flash_cs_n <= 1'b1;
            sd_cs_n    <= 1'b1;
            tgt_sd     <= 1'b0;
            rx_buf     <= '1;
            dout_q     <= '1;
        end else begin
            prev <= cur;
            if (rise.fcw)
                flash_cs_n <= bus.din[0];
            if (disable_spisd)
                sd_cs_n <= 1'b1;
            else if (rise.scw)
                sd_cs_n <= bus.din[0];
            if (start_req && !busy)
                tgt_sd <= !start_flash;
            if (done)
                rx_buf <= rx_byte;
            // Reads return the byte of the previous transfer; the new one lands in rx_buf later.
            if (rise.fr || rise.sr)
                dout_q <= rx_buf;
            else if (rise.fcr)
                dout_q <= {7'b0, flash_cs_n};
        end
    end

    spi_shifter u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start   (start_req && !busy),
        .tx_byte (tx_byte),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .busy    (busy),
        .done    (done),
        .rx_byte (rx_byte)
    );

    assign miso      = tgt_sd ? sd_miso : flash_do;
    assign flash_clk = !tgt_sd && sclk;
    assign flash_di  = tgt_sd || mosi;
    assign sd_clk    = tgt_sd && sclk;
    assign sd_mosi   = !tgt_sd || mosi;

    assign bus.dout = dout_q;
    assign bus.oe   = cur.fr || cur.sr || cur.fcr;

`ifdef SPI_WAIT_EN
    assign bus.wait_n = !busy;
`else
    assign bus.wait_n = 1'b1;
`endif

endmodule

// File: tb/tb_flash_sd_spi_ctrl.sv
// Directed, table-driven bench for flash_sd_spi_ctrl with simple flash/SD MISO models.
module tb_flash_sd_spi_ctrl;

    typedef enum logic [1:0] {OP_ZXW, OP_ZXR, OP_IOW, OP_IOR} op_t;

    typedef struct {
        op_t        op;
        logic [7:0] adr;
        logic [7:0] data;
        logic       boot;
        logic       dis;
        logic [7:0] fpat;
        logic [7:0] spat;
        logic       e_fcs;
        logic       e_scs;
        int         e_frise;
        int         e_srise;
        logic [7:0] e_mosi;
        logic       e_oe;
        logic [7:0] e_dout;
    } vec_t;

    localparam int NV = 19;

    logic clk = 1'b0;
    logic rst;
    logic in_boot_mode, disable_spisd;
    logic flash_cs_n, flash_clk, flash_di, flash_do;
    logic sd_cs_n, sd_clk, sd_mosi, sd_miso;

    flash_sd_spi_ctrl_if bus();

    flash_sd_spi_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .in_boot_mode  (in_boot_mode),
        .flash_cs_n    (flash_cs_n),
        .flash_clk     (flash_clk),
        .flash_di      (flash_di),
        .flash_do      (flash_do),
        .disable_spisd (disable_spisd),
        .sd_cs_n       (sd_cs_n),
        .sd_clk        (sd_clk),
        .sd_mosi       (sd_mosi),
        .sd_miso       (sd_miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frises = 0, srises = 0, fneg = 0, sneg = 0, wlow = 0;
    int fbase = 0, sbase = 0;
    logic [7:0] fmosi = 8'h00, smosi = 8'h00, fpat = 8'hFF, spat = 8'hFF;
    int fk, sk;

    always @(posedge flash_clk) begin
        frises <= frises + 1;
        fmosi  <= {fmosi[6:0], flash_di};
    end
    always @(posedge sd_clk) begin
        srises <= srises + 1;
        smosi  <= {smosi[6:0], sd_mosi};
    end
    always @(negedge flash_clk) fneg <= fneg + 1;
    always @(negedge sd_clk)    sneg <= sneg + 1;
    always @(posedge clk) if (bus.wait_n === 1'b0) wlow <= wlow + 1;

    // Mode-0 slaves: first bit valid at load, next bit after each falling SPI clock.
    always_comb begin
        fk       = fneg - fbase;
        sk       = sneg - sbase;
        flash_do = (fk >= 0 && fk < 8) ? fpat[3'(7 - fk)] : 1'b1;
        sd_miso  = (sk >= 0 && sk < 8) ? spat[3'(7 - sk)] : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input op_t op, input logic [7:0] adr, input logic [7:0] d, input logic en);
        bus.a      = 16'h0000;
        bus.iorq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.addr   = 8'h00;
        bus.ior    = 1'b0;
        bus.iow    = 1'b0;
        bus.din    = d;
        if (en) begin
            case (op)
                OP_ZXW: begin bus.addr = adr; bus.iow = 1'b1; end
                OP_ZXR: begin bus.addr = adr; bus.ior = 1'b1; end
                OP_IOW: begin bus.a = {8'h12, adr}; bus.iorq_n = 1'b0; bus.wr_n = 1'b0; end
                OP_IOR: begin bus.a = {8'h12, adr}; bus.iorq_n = 1'b0; bus.rd_n = 1'b0; end
                default: ;
            endcase
        end
    endtask

    task automatic access(input op_t op, input logic [7:0] adr, input logic [7:0] d, input int hold);
        drive(op, adr, d, 1'b1);
        repeat (hold) @(negedge clk);
        drive(op, adr, d, 1'b0);
    endtask

    function automatic int exp_wait(input int rises);
`ifdef SPI_WAIT_EN
        return (rises == 8) ? 16 : 0;
`else
        return (rises < 0) ? 1 : 0;
`endif
    endfunction

    vec_t vecs [NV];
    int   f0, s0, w0;
    logic oe_s;
    logic [7:0] dout_s;

    initial begin
        //          op      adr    din    bt  ds  fpat   spat   fcs scs fr sr mosi   oe  dout
        vecs[0]  = '{OP_ZXW, 8'h03, 8'h00, 1, 0, 8'hFF, 8'hFF, 0, 1, 0, 0, 8'h00, 0, 8'h00};
        vecs[1]  = '{OP_ZXW, 8'h03, 8'h01, 0, 0, 8'hFF, 8'hFF, 0, 1, 0, 0, 8'h00, 0, 8'h00};
        vecs[2]  = '{OP_ZXW, 8'h02, 8'hA5, 1, 0, 8'hAA, 8'hFF, 0, 1, 8, 0, 8'hA5, 0, 8'h00};
        vecs[3]  = '{OP_ZXR, 8'h02, 8'h00, 1, 0, 8'hE7, 8'hFF, 0, 1, 8, 0, 8'hFF, 1, 8'hAA};
        vecs[4]  = '{OP_ZXR, 8'h02, 8'h00, 1, 0, 8'h00, 8'hFF, 0, 1, 8, 0, 8'hFF, 1, 8'hE7};
        vecs[5]  = '{OP_ZXR, 8'h03, 8'h00, 1, 0, 8'hFF, 8'hFF, 0, 1, 0, 0, 8'h00, 1, 8'h00};
        vecs[6]  = '{OP_ZXW, 8'h03, 8'hFF, 1, 0, 8'hFF, 8'hFF, 1, 1, 0, 0, 8'h00, 0, 8'h00};
        vecs[7]  = '{OP_ZXR, 8'h03, 8'h00, 1, 0, 8'hFF, 8'hFF, 1, 1, 0, 0, 8'h00, 1, 8'h01};
        vecs[8]  = '{OP_ZXW, 8'h02, 8'h3C, 0, 0, 8'hFF, 8'hFF, 1, 1, 0, 0, 8'h00, 0, 8'h00};
        vecs[9]  = '{OP_ZXR, 8'h02, 8'h00, 0, 0, 8'hFF, 8'hFF, 1, 1, 0, 0, 8'h00, 0, 8'h00};
        vecs[10] = '{OP_IOW, 8'hE7, 8'h00, 1, 0, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 8'h00};
        vecs[11] = '{OP_IOW, 8'hEB, 8'h40, 1, 0, 8'hFF, 8'h5A, 1, 0, 0, 8, 8'h40, 0, 8'h00};
        vecs[12] = '{OP_IOR, 8'hEB, 8'h00, 1, 0, 8'hFF, 8'hC3, 1, 0, 0, 8, 8'hFF, 1, 8'h5A};
        vecs[13] = '{OP_IOW, 8'hE7, 8'h01, 1, 0, 8'hFF, 8'hFF, 1, 1, 0, 0, 8'h00, 0, 8'h00};
        vecs[14] = '{OP_IOW, 8'hE7, 8'h00, 1, 1, 8'hFF, 8'hFF, 1, 1, 0, 0, 8'h00, 0, 8'h00};
        vecs[15] = '{OP_IOW, 8'hEB, 8'h55, 1, 1, 8'hFF, 8'hFF, 1, 1, 0, 0, 8'h00, 0, 8'h00};
        vecs[16] = '{OP_IOR, 8'hEB, 8'h00, 1, 1, 8'hFF, 8'hFF, 1, 1, 0, 0, 8'h00, 0, 8'h00};
        vecs[17] = '{OP_IOR, 8'hEB, 8'h00, 1, 0, 8'hFF, 8'h81, 1, 1, 0, 8, 8'hFF, 1, 8'hC3};
        vecs[18] = '{OP_ZXR, 8'h02, 8'h00, 1, 0, 8'h12, 8'hFF, 1, 1, 8, 0, 8'hFF, 1, 8'h81};

        rst = 1'b1;
        in_boot_mode = 1'b1;
        disable_spisd = 1'b0;
        drive(OP_ZXW, 8'h00, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check("rst_flash_cs_n", flash_cs_n, 1);
        check("rst_sd_cs_n", sd_cs_n, 1);
        check("rst_flash_clk", flash_clk, 0);
        check("rst_sd_clk", sd_clk, 0);
        check("rst_flash_di", flash_di, 1);
        check("rst_sd_mosi", sd_mosi, 1);
        check("rst_wait_n", bus.wait_n, 1);
        check("rst_oe", bus.oe, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            in_boot_mode  = vecs[i].boot;
            disable_spisd = vecs[i].dis;
            fpat = vecs[i].fpat;
            spat = vecs[i].spat;
            fbase = fneg;
            sbase = sneg;
            f0 = frises;
            s0 = srises;
            w0 = wlow;
            drive(vecs[i].op, vecs[i].adr, vecs[i].data, 1'b1);
            repeat (2) @(negedge clk);
            oe_s = bus.oe;
            dout_s = bus.dout;
            @(negedge clk);
            drive(vecs[i].op, vecs[i].adr, vecs[i].data, 1'b0);
            repeat (22) @(negedge clk);
            check($sformatf("v%0d_flash_cs_n", i), flash_cs_n, vecs[i].e_fcs);
            check($sformatf("v%0d_sd_cs_n", i), sd_cs_n, vecs[i].e_scs);
            check($sformatf("v%0d_flash_clk_rises", i), frises - f0, vecs[i].e_frise);
            check($sformatf("v%0d_sd_clk_rises", i), srises - s0, vecs[i].e_srise);
            check($sformatf("v%0d_oe", i), oe_s, vecs[i].e_oe);
            check($sformatf("v%0d_wait_low", i), wlow - w0, exp_wait(vecs[i].e_frise + vecs[i].e_srise));
            if (vecs[i].e_frise == 8)
                check($sformatf("v%0d_flash_di", i), fmosi, vecs[i].e_mosi);
            if (vecs[i].e_srise == 8)
                check($sformatf("v%0d_sd_mosi", i), smosi, vecs[i].e_mosi);
            if (vecs[i].e_oe)
                check($sformatf("v%0d_dout", i), dout_s, vecs[i].e_dout);
        end

        // Start while busy must not restart or alter the running transfer.
        in_boot_mode = 1'b1;
        disable_spisd = 1'b0;
        fpat = 8'h3C;
        fbase = fneg;
        f0 = frises;
        w0 = wlow;
        access(OP_ZXW, 8'h02, 8'h81, 3);
        @(negedge clk);
        access(OP_ZXW, 8'h02, 8'h0F, 2);
        repeat (22) @(negedge clk);
        check("busy_flash_clk_rises", frises - f0, 8);
        check("busy_flash_di", fmosi, 8'h81);
        check("busy_wait_low", wlow - w0, exp_wait(8));
        fpat = 8'h00;
        fbase = fneg;
        drive(OP_ZXR, 8'h02, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        check("busy_rx_dout", bus.dout, 8'h3C);
        drive(OP_ZXR, 8'h02, 8'h00, 1'b0);
        repeat (22) @(negedge clk);

        // Reset in the middle of a transfer aborts to reset values.
        access(OP_ZXW, 8'h03, 8'h00, 2);
        @(negedge clk);
        check("abort_pre_flash_cs_n", flash_cs_n, 0);
        f0 = frises;
        access(OP_ZXW, 8'h02, 8'hF0, 2);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_flash_clk", flash_clk, 0);
        check("abort_flash_di", flash_di, 1);
        check("abort_flash_cs_n", flash_cs_n, 1);
        check("abort_wait_n", bus.wait_n, 1);
        check("abort_partial_rises", (frises - f0) < 8, 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_resume", flash_clk, 0);
        drive(OP_ZXR, 8'h02, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        check("abort_rx_buf_reset", bus.dout, 8'hFF);
        check("abort_read_oe", bus.oe, 1);
        drive(OP_ZXR, 8'h02, 8'h00, 1'b0);
        repeat (22) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
